// File: rtl/div_freq_meter_if.sv
// Signal bundle between a divider-tap frequency meter and its controller.
interface div_freq_meter_if #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
);
   logic [3:0]       sig_in;
   logic [1:0]       sel;
   logic [WIN_W-1:0] window;
   logic             start;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output sig_in, sel, window, start,
      input  busy, done, count, overflow
   );

   modport slave (
      input  sig_in, sel, window, start,
      output busy, done, count, overflow
   );
endinterface

// File: rtl/div_freq_meter.sv
// Gated edge counter: counts rising edges of one selected divider tap over a
// programmable window of clk cycles and reports a saturating result.
module div_freq_meter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   div_freq_meter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

   state_t           state;
   logic [3:0]       sig_q;
   logic             prev;
   logic [1:0]       sel_q;
   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] gate;
   logic [CNT_W-1:0] edge_cnt;
   logic             ovf;

   logic             sig_sel;
   logic             rise;
   logic             sat;
   logic [CNT_W-1:0] edge_next;
   logic             ovf_next;

   // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sig_sel   = sig_q[sel_q];
      rise      = sig_sel & ~prev;
      sat       = &edge_cnt;
      edge_next = edge_cnt;
      ovf_next  = ovf;
      if (rise) begin
         if (sat) ovf_next = 1'b1;
         else     edge_next = edge_cnt + CNT_W'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sig_q        <= '0;
         prev         <= 1'b0;
         sel_q        <= '0;
         win_q        <= '0;
         gate         <= '0;
         edge_cnt     <= '0;
         ovf          <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.count    <= '0;
         bus.overflow <= 1'b0;
      end else begin
         sig_q    <= bus.sig_in;
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  if (bus.window != '0) begin
                     sel_q <= bus.sel;
                     win_q <= bus.window;
                     state <= ARM;
                  end else begin
                     // Empty window: report a zero result immediately.
                     bus.done     <= 1'b1;
                     bus.count    <= '0;
                     bus.overflow <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            ARM: begin
               edge_cnt <= '0;
               ovf      <= 1'b0;
               prev     <= sig_sel;
               gate     <= win_q;
               state    <= MEASURE;
            end
            MEASURE: begin
               prev     <= sig_sel;
               gate     <= gate - WIN_W'(1);
               edge_cnt <= edge_next;
               ovf      <= ovf_next;
               // Result registers take the post-increment value so the last gated edge is counted.
               if (gate == WIN_W'(1)) begin
                  bus.done     <= 1'b1;
                  bus.count    <= edge_next;
                  bus.overflow <= ovf_next;
                  state        <= DONE;
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/div_freq_meter.md
DIV_FREQ_METER -- requirements
Module: div_freq_meter

Interface
REQ-001 Parameter: CNT_W, 8, width of the edge counter and count output.
REQ-002 Parameter: WIN_W, 8, width of the gate-window length input.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: sig_in  input  4  divided-clock taps from the upstream divider: [0]=divideby2, [1]=divideby4, [2]=divideby8, [3]=divideby16; all generated in the clk domain.
REQ-006 Port: sel  input  2  selects which sig_in bit is measured.
REQ-007 Port: window  input  WIN_W  gate length, in clk cycles.
REQ-008 Port: start  input  1  request to begin a measurement; level-sampled.
REQ-009 Port: busy  output  1  high while a measurement is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking a new result.
REQ-011 Port: count  output  CNT_W  rising-edge count from the last completed measurement.
REQ-012 Port: overflow  output  1  the last result saturated.

Function
REQ-013 sig_in SHALL be registered once (sig_q) before use; edge detection SHALL use sig_q versus prev, where prev is the previous sig_q of the selected bit.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE and DONE.
REQ-015 IDLE: busy=0; start=1 with window!=0 SHALL latch sel and window and go to ARM.
REQ-016 IDLE: start=1 with window==0 SHALL go directly to DONE, producing count=0 and overflow=0.
REQ-017 ARM (1 cycle): busy=1; clear the edge counter and overflow flag; load prev with the selected sig_q; load the gate counter with the latched window; go to MEASURE.
REQ-018 MEASURE: busy=1; in each cycle with selected sig_q=1 and prev=0, the edge counter SHALL increment.
REQ-019 MEASURE: prev SHALL update every cycle.
REQ-020 MEASURE: the gate counter SHALL decrement every cycle; the cycle in which it reads 1 is the last MEASURE cycle, and the next state SHALL be DONE.
REQ-021 MEASURE SHALL last exactly window cycles, and the last cycle's edge SHALL be included in the result.
REQ-022 The edge counter SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set the internal overflow flag.
REQ-023 DONE (1 cycle): done=1 and busy=1; count and overflow outputs SHALL load the final counter and flag values in this cycle; the next state SHALL be IDLE.
REQ-024 Latency: with start sampled in IDLE at edge k, done SHALL be high in cycle k+2+window; the window==0 case SHALL have done high in cycle k+1.
REQ-025 start SHALL be ignored in ARM, MEASURE and DONE; start held high SHALL retrigger from IDLE in the cycle after DONE.
REQ-026 Changes to sel or window while busy=1 SHALL NOT affect the measurement in progress.
REQ-027 count and overflow SHALL hold their values between results; they SHALL change only in DONE or on reset.

Reset
REQ-028 rst=1 at a clock edge SHALL force the IDLE state from any state, including mid-MEASURE, with no done pulse.
REQ-029 Reset values SHALL be: busy=0, done=0, count=0, overflow=0, edge counter=0, gate counter=0, prev=0, sig_q=0, latched sel=0, latched window=0.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-031 sel=0, window=32, divideby2 toggling every cycle, start pulsed -> done 34 cycles after start is sampled, count=16, overflow=0.
REQ-032 sel=3, window=32, divideby16, any phase -> count=2; sel=2, window=32, divideby8 -> count=4.
REQ-033 CNT_W=4, sel=0, window=64 -> count=15, overflow=1; a following run with window=8 -> count=4, overflow=0.
REQ-034 window=0, start -> done in the next cycle, count=0, busy high for that one cycle only.
REQ-035 rst=1 for one cycle midway through MEASURE -> no done pulse, busy=0 and count=0 next cycle, and a new start then measures correctly.
REQ-036 sel changed from 0 to 3 and start re-pulsed while busy -> result reflects the original sel=0 and exactly one done pulse; start held high continuously -> back-to-back runs with done every window+3 cycles.
